// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// the FSM state type, and helpers for access size and legality.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } lsu_state_t;

    // Byte mask of the access size, before shifting to the byte offset.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // 011, 11x are never legal; unsigned variants exist only for loads.
    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic write);
        return (funct3 == 3'b011) || (funct3[2] && funct3[1]) || (funct3[2] && write);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
//   master: the execute stage (drives req_*, receives req_ready and resp_*)
//   slave : the LSU
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment and extension.
//   rd_pair : {hi word, lo word} as returned by memory
//   off     : byte offset of the access within the lo word
//   funct3  : RV32I load funct3
//   rdata   : extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] rd_pair,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = 32'(rd_pair >> {off, 3'b000});

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the execute stage and a word-addressed,
// synchronous-read data memory. Misaligned accesses are split into two
// word accesses (SPLIT_EN=1) or rejected with resp_err (SPLIT_EN=0).
//   clk, rst_n : clock, synchronous active-low reset
//   core       : lsu_if.slave request/response bundle
//   mem_en     : memory access this cycle
//   mem_we     : byte lane write enables
//   mem_addr   : word address
//   mem_wdata  : lane-aligned store data
//   mem_rdata  : read data, valid the cycle after mem_en
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_if.slave        core,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam bit SPLIT = (SPLIT_EN != 0);

    lsu_state_t  state;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic        mem_en_q;
    logic [3:0]  we_q;
    logic [29:0] maddr_q;
    logic [31:0] mwd_q;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wd_hi_q;
    logic [31:0] lo_q;

    // Lane math on the incoming request; the upper halves are kept for ACC1.
    logic [1:0]  in_off;
    logic [7:0]  in_be;
    logic [63:0] in_wd;
    logic        in_split;
    logic        in_illegal;
    logic        accept;

    assign in_off     = core.req_addr[1:0];
    assign in_be      = {4'b0000, size_mask(core.req_funct3)} << in_off;
    assign in_wd      = {32'b0, core.req_wdata} << {in_off, 3'b000};
    assign in_split   = (in_be[7:4] != 4'b0000);
    assign in_illegal = funct3_illegal(core.req_funct3, core.req_write);
    assign accept     = core.req_valid && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            we_q         <= '0;
            maddr_q      <= '0;
            mwd_q        <= '0;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            be_hi_q      <= '0;
            wd_hi_q      <= '0;
            lo_q         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q  <= 1'b0;
                        write_q  <= core.req_write;
                        funct3_q <= core.req_funct3;
                        off_q    <= in_off;
                        split_q  <= in_split;
                        be_hi_q  <= in_be[7:4];
                        wd_hi_q  <= in_wd[63:32];
                        if (in_illegal || (in_split && !SPLIT)) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state    <= ST_ACC0;
                            mem_en_q <= 1'b1;
                            maddr_q  <= core.req_addr[31:2];
                            we_q     <= core.req_write ? in_be[3:0] : 4'b0000;
                            mwd_q    <= in_wd[31:0];
                        end
                    end
                end
                ST_ACC0: begin
                    if (split_q) begin
                        state   <= ST_ACC1;
                        maddr_q <= maddr_q + 30'd1;
                        we_q    <= write_q ? be_hi_q : 4'b0000;
                        mwd_q   <= wd_hi_q;
                    end else begin
                        state        <= ST_RESP;
                        mem_en_q     <= 1'b0;
                        we_q         <= '0;
                        resp_valid_q <= 1'b1;
                    end
                end
                ST_ACC1: begin
                    // Read data of the ACC0 access arrives in this cycle.
                    lo_q         <= mem_rdata;
                    state        <= ST_RESP;
                    mem_en_q     <= 1'b0;
                    we_q         <= '0;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    ready_q      <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [63:0] rd_pair;
    logic [31:0] load_data;

    assign rd_pair = split_q ? {mem_rdata, lo_q} : {32'b0, mem_rdata};

    lsu_load_align u_align (
        .rd_pair (rd_pair),
        .off     (off_q),
        .funct3  (funct3_q),
        .rdata   (load_data)
    );

    assign core.req_ready  = ready_q;
    assign core.resp_valid = resp_valid_q;
    assign core.resp_err   = resp_err_q;
    assign core.resp_rdata = (resp_valid_q && !resp_err_q && !write_q) ? load_data : '0;

    assign mem_en    = mem_en_q;
    // Gated by reset so a reset landing mid-store never writes memory.
    assign mem_we    = we_q & {4{rst_n}};
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if c0();
    lsu_if c1();

    logic        m0_en, m1_en;
    logic [3:0]  m0_we, m1_we;
    logic [29:0] m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd, m0_rd, m1_rd;

    load_store_unit #(.SPLIT_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .core(c0),
        .mem_en(m0_en), .mem_we(m0_we), .mem_addr(m0_addr),
        .mem_wdata(m0_wd), .mem_rdata(m0_rd)
    );

    load_store_unit #(.SPLIT_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .core(c1),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr),
        .mem_wdata(m1_wd), .mem_rdata(m1_rd)
    );

    // Reference byte memory (1024 words, address aliased modulo 4 KiB).
    logic [31:0] refmem [1024];
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic        mem_load = 1'b0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < 1024; k++) begin
                mem0[k] <= refmem[k];
                mem1[k] <= refmem[k];
            end
        end else begin
            if (m0_en) begin
                m0_rd <= mem0[10'(m0_addr)];
                for (int i = 0; i < 4; i++)
                    if (m0_we[i]) mem0[10'(m0_addr)][8*i +: 8] <= m0_wd[8*i +: 8];
            end
            if (m1_en) begin
                m1_rd <= mem1[10'(m1_addr)];
                for (int i = 0; i < 4; i++)
                    if (m1_we[i]) mem1[10'(m1_addr)][8*i +: 8] <= m1_wd[8*i +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [31:0] w;
        w = refmem[10'(a >> 2)];
        return w[8*(a % 4) +: 8];
    endfunction

    function automatic int unsigned nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = 0;
        for (int unsigned i = 0; i < nbytes(f3); i++)
            v = v | (32'(rbyte(a + i)) << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ba;
        for (int unsigned i = 0; i < nbytes(f3); i++) begin
            ba = a + i;
            refmem[10'(ba >> 2)][8*(ba % 4) +: 8] = wd[8*i +: 8];
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] f3, input bit wr);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
    endfunction

    // ---------------- stimulus helpers ----------------
    logic [29:0] acc_addr [$];
    logic [3:0]  acc_we   [$];
    logic [31:0] acc_wd   [$];

    task automatic issue(input bit sel, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        int w;
        acc_addr.delete(); acc_we.delete(); acc_wd.delete();
        @(negedge clk);
        if (!sel) begin
            c0.req_valid = 1'b1; c0.req_write = wr; c0.req_funct3 = f3;
            c0.req_addr = a; c0.req_wdata = wd;
        end else begin
            c1.req_valid = 1'b1; c1.req_write = wr; c1.req_funct3 = f3;
            c1.req_addr = a; c1.req_wdata = wd;
        end
        w = 0;
        while (!(sel ? c1.req_ready : c0.req_ready) && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", 32'(sel ? c1.req_ready : c0.req_ready), 32'd1);
        @(posedge clk);
        #1;
        c0.req_valid = 1'b0;
        c1.req_valid = 1'b0;
        lat = 0;
        rd = 'x;
        er = 1'bx;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            lat++;
            if (sel ? m1_en : m0_en) begin
                acc_addr.push_back(sel ? m1_addr : m0_addr);
                acc_we.push_back(sel ? m1_we : m0_we);
                acc_wd.push_back(sel ? m1_wd : m0_wd);
            end
            if (sel ? c1.resp_valid : c0.resp_valid) begin
                rd = sel ? c1.resp_rdata : c0.resp_rdata;
                er = sel ? c1.resp_err : c0.resp_err;
                break;
            end
        end
    endtask

    task automatic run_op(input bit sel, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string tag, output logic [31:0] rd);
        int          lat;
        logic        er;
        bit          ill, mis, exp_err;
        int unsigned n;
        logic [31:0] exp_rd;
        n       = nbytes(f3);
        ill     = is_illegal(f3, wr);
        mis     = ((a % 4) + n) > 4;
        exp_err = ill || (mis && sel);
        exp_rd  = (wr || exp_err) ? 32'd0 : ref_load(f3, a);
        issue(sel, wr, f3, a, wd, lat, rd, er);
        chk({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : (mis ? 32'd3 : 32'd2));
        chk({tag, "_err"}, 32'(er), 32'(exp_err));
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_naccess"}, 32'(acc_addr.size()), exp_err ? 32'd0 : (mis ? 32'd2 : 32'd1));
        if (wr && !exp_err) ref_store(f3, a, wd);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(sel ? c1.resp_valid : c0.resp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(sel ? c1.req_ready : c0.req_ready), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] a, wd;
        logic [2:0]  f3;
        bit          wr;
        int          diff;
        bit          saw_resp;

        c0.req_valid = 1'b0; c0.req_write = 1'b0; c0.req_funct3 = '0; c0.req_addr = '0; c0.req_wdata = '0;
        c1.req_valid = 1'b0; c1.req_write = 1'b0; c1.req_funct3 = '0; c1.req_addr = '0; c1.req_wdata = '0;
        for (int k = 0; k < 1024; k++) refmem[k] = $urandom;
        refmem[32'h40] = 32'hDEAD_BEEF;
        refmem[1]      = 32'h4433_2211;
        refmem[2]      = 32'h8877_6655;

        mem_load = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_load = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", 32'(c0.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(c0.resp_valid), 32'd0);
        chk("rst_resp_rdata", c0.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(c0.resp_err), 32'd0);
        chk("rst_mem_en", 32'(m0_en), 32'd0);
        chk("rst_mem_we", 32'(m0_we), 32'd0);
        chk("rst_mem_addr", 32'(m0_addr), 32'd0);
        chk("rst_mem_wdata", m0_wd, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // SPLIT_EN=0 instance, before any store changes the shared image.
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'd0, "ns_lw_aligned", rd);
        chk("ns_lw_value", rd, 32'hDEAD_BEEF);
        run_op(1'b1, 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, "ns_lw_wrap", rd);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_0003, 32'd0, "ns_lh_mis", rd);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_0003, 32'd0, "ns_lb", rd);
        run_op(1'b1, 1'b1, 3'd2, 32'h0000_0201, 32'h1234_5678, "ns_sw_mis", rd);

        // SPLIT_EN=1 instance.
        run_op(1'b0, 1'b0, 3'd2, 32'h0000_0100, 32'd0, "lw_100", rd);
        chk("lw_100_value", rd, 32'hDEAD_BEEF);
        chk("lw_100_addr", 32'(acc_addr[0]), 32'h40);
        chk("lw_100_we", 32'(acc_we[0]), 32'd0);

        run_op(1'b0, 1'b1, 3'd2, 32'h0000_0100, 32'h80FF_0000, "sw_100", rd);
        chk("sw_100_we", 32'(acc_we[0]), 32'hF);
        run_op(1'b0, 1'b0, 3'd0, 32'h0000_0103, 32'd0, "lb_103", rd);
        chk("lb_103_value", rd, 32'hFFFF_FF80);
        run_op(1'b0, 1'b0, 3'd4, 32'h0000_0103, 32'd0, "lbu_103", rd);
        chk("lbu_103_value", rd, 32'h0000_0080);

        run_op(1'b0, 1'b1, 3'd1, 32'h0000_0203, 32'h0000_ABCD, "sh_203", rd);
        chk("sh_203_addr0", 32'(acc_addr[0]), 32'h80);
        chk("sh_203_we0", 32'(acc_we[0]), 32'b1000);
        chk("sh_203_wd0", 32'(acc_wd[0][31:24]), 32'hCD);
        chk("sh_203_addr1", 32'(acc_addr[1]), 32'h81);
        chk("sh_203_we1", 32'(acc_we[1]), 32'b0001);
        chk("sh_203_wd1", 32'(acc_wd[1][7:0]), 32'hAB);

        run_op(1'b0, 1'b0, 3'd2, 32'h0000_0006, 32'd0, "lw_006", rd);
        chk("lw_006_value", rd, 32'h6655_4433);
        chk("lw_006_addr0", 32'(acc_addr[0]), 32'h1);
        chk("lw_006_addr1", 32'(acc_addr[1]), 32'h2);

        run_op(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, "lw_wrap", rd);
        chk("lw_wrap_addr0", 32'(acc_addr[0]), 32'h3FFF_FFFF);
        chk("lw_wrap_addr1", 32'(acc_addr[1]), 32'h0);

        run_op(1'b0, 1'b0, 3'd3, 32'h0000_0010, 32'd0, "ill_f3_011", rd);
        run_op(1'b0, 1'b1, 3'd4, 32'h0000_0010, 32'h55, "ill_sbu", rd);
        run_op(1'b0, 1'b0, 3'd7, 32'h0000_0013, 32'd0, "ill_f3_111", rd);

        // Reset during ACC0 of a store: no write, no response.
        @(negedge clk);
        c0.req_valid = 1'b1; c0.req_write = 1'b1; c0.req_funct3 = 3'd2;
        c0.req_addr = 32'h0000_0300; c0.req_wdata = ~refmem[32'hC0];
        @(posedge clk);
        #1;
        c0.req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_we", 32'(m0_we), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 32'(c0.req_ready), 32'd1);
        chk("rstmid_mem_en", 32'(m0_en), 32'd0);
        saw_resp = c0.resp_valid;
        repeat (3) begin
            @(negedge clk);
            saw_resp = saw_resp | c0.resp_valid;
        end
        chk("rstmid_no_resp", 32'(saw_resp), 32'd0);
        chk("rstmid_mem_kept", mem0[32'hC0], refmem[32'hC0]);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 200; t++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3))
                                               : 32'($urandom_range(0, 4095));
            wd = $urandom;
            run_op(1'b0, wr, f3, a, wd, "rand", rd);
        end

        diff = 0;
        for (int k = 0; k < 1024; k++)
            if (mem0[k] !== refmem[k]) diff++;
        chk("final_mem_diff_words", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
